// File: rtl/mem_pkg.sv
// Shared constants for the data-memory access path: RV32 load/store width
// codes, controller state encoding and the BRAM byte-enable width.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ACCESS  = 2'd1;
  localparam logic [1:0] S_RD_DATA = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  localparam int BE_W = 4;

endpackage

// File: rtl/lsu_load_align.sv
// Load data extraction: picks the byte/halfword lane addressed by the offset
// and sign- or zero-extends it according to the RV32 load funct3.
module lsu_load_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection and extension
  always_comb begin
    byte_s = 8'd0;
    half_s = 16'd0;
    data   = 32'd0;
    case (offset)
      2'd0:    byte_s = word[7:0];
      2'd1:    byte_s = word[15:8];
      2'd2:    byte_s = word[23:16];
      2'd3:    byte_s = word[31:24];
      default: byte_s = 8'd0;
    endcase
    if (offset[1]) begin
      half_s = word[31:16];
    end else begin
      half_s = word[15:0];
    end
    case (funct3)
      F3_B:    data = {{24{byte_s[7]}}, byte_s};
      F3_H:    data = {{16{half_s[15]}}, half_s};
      F3_W:    data = word;
      F3_BU:   data = {24'd0, byte_s};
      F3_HU:   data = {16'd0, half_s};
      default: data = 32'd0;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Single-outstanding RV32 load/store controller in front of a 1-cycle-latency
// word-addressed BRAM; all memory and response outputs are registered.
module dmem_access_ctrl
  import mem_pkg::*;
#(
  parameter int          ADDR_W    = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic [BE_W-1:0]   mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);

  logic [1:0]        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic              mem_en_q, mem_en_d;
  logic [BE_W-1:0]   mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_din_q, mem_din_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;

  logic              accept_s, err_s, f3_ok_s, misalign_s, range_bad_s;
  logic [BE_W-1:0]   we_lanes_s;
  logic [31:0]       din_lanes_s;
  logic [31:0]       load_data_s;

  assign req_ready = (state_q == S_IDLE);
  assign accept_s  = req_valid && req_ready;

  // Request legality: funct3 for the direction, natural alignment, window
  always_comb begin
    f3_ok_s    = 1'b0;
    misalign_s = 1'b0;
    case (req_funct3)
      F3_B, F3_H, F3_W: f3_ok_s = 1'b1;
      F3_BU, F3_HU:     f3_ok_s = !req_we;
      default:          f3_ok_s = 1'b0;
    endcase
    case (req_funct3)
      F3_H, F3_HU: misalign_s = req_addr[0];
      F3_W:        misalign_s = (req_addr[1:0] != 2'b00);
      default:     misalign_s = 1'b0;
    endcase
    range_bad_s = (req_addr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2]);
    err_s       = !f3_ok_s || misalign_s || range_bad_s;
  end

  // Store byte enables and lane-replicated write data
  always_comb begin
    we_lanes_s  = {BE_W{1'b0}};
    din_lanes_s = 32'd0;
    case (req_funct3)
      F3_B: begin
        we_lanes_s  = 4'b0001 << req_addr[1:0];
        din_lanes_s = {4{req_wdata[7:0]}};
      end
      F3_H: begin
        if (req_addr[1]) begin
          we_lanes_s = 4'b1100;
        end else begin
          we_lanes_s = 4'b0011;
        end
        din_lanes_s = {2{req_wdata[15:0]}};
      end
      F3_W: begin
        we_lanes_s  = 4'b1111;
        din_lanes_s = req_wdata;
      end
      default: begin
        we_lanes_s  = {BE_W{1'b0}};
        din_lanes_s = 32'd0;
      end
    endcase
  end

  lsu_load_align u_load_align (
    .word   (mem_dout),
    .offset (off_q),
    .funct3 (f3_q),
    .data   (load_data_s)
  );

  // FSM and next values of the registered outputs
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    off_d   = off_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          we_d  = req_we;
          f3_d  = req_funct3;
          off_d = req_addr[1:0];
          if (err_s) begin
            state_d = S_RESP;
          end else begin
            state_d = S_ACCESS;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (we_q) begin
          state_d = S_RESP;
        end else begin
          state_d = S_RD_DATA;
        end
      end
      S_RD_DATA: state_d = S_RESP;
      S_RESP:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    mem_en_d     = (state_d == S_ACCESS) || (state_d == S_RD_DATA);
    mem_we_d     = {BE_W{1'b0}};
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    if (accept_s && !err_s) begin
      mem_addr_d = req_addr[ADDR_W+1:2];
      if (req_we) begin
        mem_we_d  = we_lanes_s;
        mem_din_d = din_lanes_s;
      end else begin
        mem_we_d  = {BE_W{1'b0}};
      end
    end else begin
      mem_we_d = {BE_W{1'b0}};
    end

    resp_valid_d = (state_d == S_RESP);
    // Only an IDLE-to-RESP hop carries an error; good responses clear it
    resp_err_d   = accept_s && err_s;
    if (state_q == S_RD_DATA) begin
      resp_rdata_d = load_data_s;
    end else begin
      resp_rdata_d = 32'd0;
    end
  end

  // State, captured request and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      f3_q         <= 3'b000;
      off_q        <= 2'b00;
      mem_en_q     <= 1'b0;
      mem_we_q     <= {BE_W{1'b0}};
      mem_addr_q   <= {ADDR_W{1'b0}};
      mem_din_q    <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      off_q        <= off_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a small behavioural BRAM model.
module tb_dmem_access_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_din;
  logic [31:0] mem_dout;

  int pass_cnt;
  int total_cnt;

  logic [31:0] ram [0:63];

  dmem_access_ctrl #(.ADDR_W(16), .BASE_ADDR(32'h0000_0000)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first BRAM; output is garbage whenever the port is not enabled
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) ram[mem_addr[5:0]][b*8 +: 8] <= mem_din[b*8 +: 8];
      end
      mem_dout <= ram[mem_addr[5:0]];
    end else begin
      mem_dout <= 32'hBAD0_BAD0;
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    int n;
    n = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      total_cnt++;
      $display("FAIL issue_timeout: req_ready=%b required 1", req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({req_ready, resp_valid, resp_err, mem_en} !== 4'b1000)
      $display("FAIL reset_ctrl: ready/valid/err/en=%b required 1000",
               {req_ready, resp_valid, resp_err, mem_en});
    else pass_cnt++;
    total_cnt++;
    if ({mem_we, mem_addr, mem_din, resp_rdata} !== 84'd0)
      $display("FAIL reset_data: we=%h addr=%h din=%h rdata=%h required all 0",
               mem_we, mem_addr, mem_din, resp_rdata);
    else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_sw;
    issue(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
    total_cnt++;
    if ({mem_en, mem_we, mem_addr, mem_din} !== {1'b1, 4'b1111, 16'h0004, 32'hDEAD_BEEF})
      $display("FAIL sw_access: en=%b we=%b addr=%h din=%h required 1 1111 0004 deadbeef",
               mem_en, mem_we, mem_addr, mem_din);
    else pass_cnt++;
    total_cnt++;
    if ({req_ready, resp_valid} !== 2'b00)
      $display("FAIL sw_busy: ready/valid=%b required 00", {req_ready, resp_valid});
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({resp_valid, resp_err, resp_rdata, mem_en, mem_we} !== {2'b10, 32'd0, 1'b0, 4'b0000})
      $display("FAIL sw_resp: valid=%b err=%b rdata=%h en=%b we=%b required 1 0 0 0 0",
               resp_valid, resp_err, resp_rdata, mem_en, mem_we);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({resp_valid, req_ready} !== 2'b01)
      $display("FAIL sw_idle: valid/ready=%b required 01", {resp_valid, req_ready});
    else pass_cnt++;
  endtask

  task automatic check_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] exp);
    issue(1'b0, f3, addr, 32'd0);
    total_cnt++;
    if ({mem_en, mem_we, mem_addr} !== {1'b1, 4'b0000, addr[17:2]})
      $display("FAIL %s_access: en=%b we=%b addr=%h required 1 0000 %h",
               name, mem_en, mem_we, mem_addr, addr[17:2]);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({mem_en, resp_valid, mem_addr} !== {2'b10, addr[17:2]})
      $display("FAIL %s_rddata: en=%b valid=%b addr=%h required 1 0 %h",
               name, mem_en, resp_valid, mem_addr, addr[17:2]);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({resp_valid, resp_err, resp_rdata, mem_en} !== {2'b10, exp, 1'b0})
      $display("FAIL %s_resp: valid=%b err=%b rdata=%h en=%b required 1 0 %h 0",
               name, resp_valid, resp_err, resp_rdata, mem_en, exp);
    else pass_cnt++;
  endtask

  task automatic test_byte;
    issue(1'b1, 3'b000, 32'h13, 32'h0000_00A5);
    total_cnt++;
    if ({mem_we, mem_din, mem_addr} !== {4'b1000, 32'hA5A5_A5A5, 16'h0004})
      $display("FAIL sb_lanes: we=%b din=%h addr=%h required 1000 a5a5a5a5 0004",
               mem_we, mem_din, mem_addr);
    else pass_cnt++;
    @(negedge clk);
    check_load("lb",  3'b000, 32'h13, 32'hFFFF_FFA5);
    check_load("lbu", 3'b100, 32'h13, 32'h0000_00A5);
    check_load("lw_merge", 3'b010, 32'h10, 32'hA5AD_BEEF);
  endtask

  task automatic test_half;
    issue(1'b1, 3'b010, 32'h20, 32'h8001_7FFF);
    @(negedge clk);
    check_load("lh",  3'b001, 32'h22, 32'hFFFF_8001);
    check_load("lhu", 3'b101, 32'h20, 32'h0000_7FFF);
    issue(1'b1, 3'b001, 32'h22, 32'h0000_1234);
    total_cnt++;
    if ({mem_we, mem_din} !== {4'b1100, 32'h1234_1234})
      $display("FAIL sh_lanes: we=%b din=%h required 1100 12341234", mem_we, mem_din);
    else pass_cnt++;
    @(negedge clk);
    check_load("lw_sh", 3'b010, 32'h20, 32'h1234_7FFF);
  endtask

  task automatic test_errors;
    logic        we_t  [5];
    logic [2:0]  f3_t  [5];
    logic [31:0] adr_t [5];
    we_t[0] = 1'b0; f3_t[0] = 3'b010; adr_t[0] = 32'h0000_0021;
    we_t[1] = 1'b1; f3_t[1] = 3'b001; adr_t[1] = 32'h0000_0003;
    we_t[2] = 1'b0; f3_t[2] = 3'b011; adr_t[2] = 32'h0000_0000;
    we_t[3] = 1'b0; f3_t[3] = 3'b010; adr_t[3] = 32'h0004_0000;
    we_t[4] = 1'b1; f3_t[4] = 3'b100; adr_t[4] = 32'h0000_0008;
    for (int i = 0; i < 5; i++) begin
      issue(we_t[i], f3_t[i], adr_t[i], 32'hFFFF_FFFF);
      total_cnt++;
      if ({resp_valid, resp_err, resp_rdata, mem_en, mem_we} !== {2'b11, 32'd0, 1'b0, 4'b0000})
        $display("FAIL err_%0d: valid=%b err=%b rdata=%h en=%b we=%b required 1 1 0 0 0",
                 i, resp_valid, resp_err, resp_rdata, mem_en, mem_we);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({resp_valid, resp_err, mem_en, req_ready} !== 4'b0001)
        $display("FAIL err_%0d_after: valid/err/en/ready=%b required 0001",
                 i, {resp_valid, resp_err, mem_en, req_ready});
      else pass_cnt++;
    end
    issue(1'b0, 3'b010, 32'h0003_FFFC, 32'd0);
    total_cnt++;
    if ({mem_en, mem_addr} !== {1'b1, 16'hFFFF})
      $display("FAIL edge_window: en=%b addr=%h required 1 ffff", mem_en, mem_addr);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({resp_valid, resp_err} !== 2'b10)
      $display("FAIL edge_window_resp: valid/err=%b required 10", {resp_valid, resp_err});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [7:0]  rdy_v, vld_v;
    logic [31:0] last_rdata;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h30; req_wdata = 32'h1111_1111;
    for (int i = 0; i < 8; i++) begin
      rdy_v[7-i] = req_ready;
      vld_v[7-i] = resp_valid;
      @(negedge clk);
    end
    req_valid = 1'b0;
    total_cnt++;
    if ({rdy_v, vld_v} !== {8'b1001_0010, 8'b0010_0100})
      $display("FAIL b2b_store: ready=%b valid=%b required 10010010 00100100", rdy_v, vld_v);
    else pass_cnt++;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0;
    last_rdata = 32'd0;
    for (int i = 0; i < 8; i++) begin
      rdy_v[7-i] = req_ready;
      vld_v[7-i] = resp_valid;
      if (i == 7) last_rdata = resp_rdata;
      @(negedge clk);
    end
    req_valid = 1'b0;
    total_cnt++;
    if ({rdy_v, vld_v} !== {8'b1000_1000, 8'b0001_0001})
      $display("FAIL b2b_load: ready=%b valid=%b required 10001000 00010001", rdy_v, vld_v);
    else pass_cnt++;
    total_cnt++;
    if (last_rdata !== 32'h1111_1111)
      $display("FAIL b2b_load_data: rdata=%h required 11111111", last_rdata);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    logic seen;
    issue(1'b0, 3'b010, 32'h10, 32'd0);
    @(negedge clk);
    total_cnt++;
    if (mem_en !== 1'b1)
      $display("FAIL mid_rd_en: en=%b required 1", mem_en);
    else pass_cnt++;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({mem_en, mem_we, req_ready} !== {1'b0, 4'b0000, 1'b1})
      $display("FAIL mid_rst_async: en=%b we=%b ready=%b required 0 0000 1",
               mem_en, mem_we, req_ready);
    else pass_cnt++;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    rst_n = 1'b1;
    total_cnt++;
    if (seen !== 1'b0)
      $display("FAIL mid_rst_noresp: resp_valid seen=%b required 0", seen);
    else pass_cnt++;
    check_load("post_rst", 3'b010, 32'h10, 32'hA5AD_BEEF);
  endtask

  initial begin
    pass_cnt   = 0;
    total_cnt  = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    mem_dout   = 32'd0;
    for (int i = 0; i < 64; i++) ram[i] = 32'd0;
    test_reset();
    test_sw();
    test_byte();
    test_half();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
